// File: rtl/rx_symbol_sequencer.sv
// RX symbol sequencer: paces FFT-buffer samples into DataRestore.
// Frames are LTS_NUM training symbols then io_numDataSym data symbols.
module rx_symbol_sequencer #(
  parameter int SAMP_PERIOD = 4,
  parameter int SYM_LEN     = 64,
  parameter int SYM_GAP     = 15,
  parameter int LTS_NUM     = 2,
  parameter int SYM_W       = 8
) (
  input  logic             CLK,
  input  logic             Rst_n,
  input  logic             io_start,
  input  logic             io_abort,
  input  logic [SYM_W-1:0] io_numDataSym,
  input  logic             io_hold,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_dataR,
  input  logic [7:0]       s_dataI,
  output logic             o_dataEn,
  output logic [7:0]       o_dataR,
  output logic [7:0]       o_dataI,
  output logic [SYM_W-1:0] o_symbol,
  output logic             io_busy,
  output logic             io_done
);

  localparam int PW = (SAMP_PERIOD > 2) ? $clog2(SAMP_PERIOD) : 1;
  localparam int SW = (SYM_LEN > 2) ? $clog2(SYM_LEN) : 1;
  localparam int GW = (SYM_GAP > 1) ? $clog2(SYM_GAP + 1) : 1;
  localparam int TW = SYM_W + 1;

  localparam logic [PW-1:0] PACE_LOAD = PW'(SAMP_PERIOD - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SYM_LEN - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(SYM_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYM,
    GAP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    total_q, total_d;
  logic [TW-1:0]    symcnt_q, symcnt_d;
  logic [SW-1:0]    samp_q, samp_d;
  logic [PW-1:0]    pace_q, pace_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [SYM_W-1:0] symbol_q, symbol_d;
  logic             en_q, en_d;
  logic [7:0]       dr_q, dr_d;
  logic [7:0]       di_q, di_d;
  logic             hs;

  // Next-state, handshake and sample-register logic
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    symcnt_d = symcnt_q;
    samp_d   = samp_q;
    gap_d    = gap_q;
    symbol_d = symbol_q;
    en_d     = 1'b0;
    dr_d     = 8'd0;
    di_d     = 8'd0;
    hs       = (state_q == SYM) && s_valid &&
               (pace_q == '0) && !io_abort;
    pace_d   = (pace_q == '0) ? '0 : pace_q - 1'b1;
    if (hs) pace_d = PACE_LOAD;

    unique case (state_q)
      IDLE: begin
        if (io_start) begin
          state_d  = SYM;
          total_d  = TW'(LTS_NUM) + {1'b0, io_numDataSym};
          symbol_d = SYM_W'(1);
          samp_d   = '0;
          symcnt_d = '0;
          pace_d   = '0;
        end
      end
      SYM: begin
        if (hs) begin
          en_d   = 1'b1;
          dr_d   = s_dataR;
          di_d   = s_dataI;
          samp_d = samp_q + 1'b1;
          if (samp_q == SAMP_LAST) begin
            samp_d   = '0;
            symbol_d = symbol_q + 1'b1;
            symcnt_d = symcnt_q + 1'b1;
            gap_d    = GAP_LOAD;
            state_d  = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (symcnt_q == total_q) begin
          state_d = DONE;
        end else if (!io_hold) begin
          state_d = SYM;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (io_abort && state_q != IDLE) state_d = IDLE;
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      total_q  <= '0;
      symcnt_q <= '0;
      samp_q   <= '0;
      pace_q   <= '0;
      gap_q    <= '0;
      symbol_q <= '0;
      en_q     <= 1'b0;
      dr_q     <= 8'd0;
      di_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      symcnt_q <= symcnt_d;
      samp_q   <= samp_d;
      pace_q   <= pace_d;
      gap_q    <= gap_d;
      symbol_q <= symbol_d;
      en_q     <= en_d;
      dr_q     <= dr_d;
      di_q     <= di_d;
    end
  end

  assign s_ready  = hs;
  assign o_dataEn = en_q;
  assign o_dataR  = dr_q;
  assign o_dataI  = di_q;
  assign o_symbol = symbol_q;
  assign io_busy  = (state_q == SYM) || (state_q == GAP);
  assign io_done  = (state_q == DONE);

endmodule
